card_datapath: RTL and testbench

Datapath for the Baccarat round. It holds the six dealt cards (player 1–3, dealer 1–3), loading each register from the dealt-card bus when the round state machine asserts the matching load strobe. It returns the modulo-10 hand scores and the player's third card to that state machine. It also drives six active-low seven-segment displays showing each card. The block sits between the card dealer (upstream, `new_card`) and the round state machine (`load_*` in, `pscore`/`dscore`/`pcard3` out).

---
 rtl/baccarat_pkg.sv | 55 +++++
 rtl/card_datapath_if.sv | 35 +++
 rtl/card7seg.sv | 36 +++
 rtl/card_datapath.sv | 67 ++++++
 tb/tb_card_datapath.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/baccarat_pkg.sv
// Shared Baccarat definitions: card codes, active-low seven-segment glyphs,
// card valuation and the modulo-10 three-card hand score.
package baccarat_pkg;

    localparam int unsigned CARD_W  = 4;
    localparam int unsigned GLYPH_W = 7;

    localparam logic [CARD_W-1:0] CARD_EMPTY = 4'd0;
    localparam logic [CARD_W-1:0] CARD_ACE   = 4'd1;
    localparam logic [CARD_W-1:0] CARD_TEN   = 4'd10;
    localparam logic [CARD_W-1:0] CARD_JACK  = 4'd11;
    localparam logic [CARD_W-1:0] CARD_QUEEN = 4'd12;
    localparam logic [CARD_W-1:0] CARD_KING  = 4'd13;

    // Glyphs are active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [GLYPH_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [GLYPH_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [GLYPH_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [GLYPH_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [GLYPH_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [GLYPH_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [GLYPH_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [GLYPH_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [GLYPH_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [GLYPH_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [GLYPH_W-1:0] SEG_J     = 7'b1100001;
    localparam logic [GLYPH_W-1:0] SEG_Q     = 7'b0011000;
    localparam logic [GLYPH_W-1:0] SEG_K     = 7'b0001010;
    localparam logic [GLYPH_W-1:0] SEG_BLANK = 7'b1111111;

    // Pip cards count face value; tens, faces and empty codes count zero
    function automatic logic [CARD_W-1:0] card_value(input logic [CARD_W-1:0] code);
        if (code >= 4'd1 && code <= 4'd9) begin
            return code;
        end
        return 4'd0;
    endfunction

    // Hand score from three raw card codes; sum peaks at 27 so two
    // conditional subtractions complete the mod-10
    function automatic logic [CARD_W-1:0] mod10_sum3(input logic [CARD_W-1:0] a,
                                                     input logic [CARD_W-1:0] b,
                                                     input logic [CARD_W-1:0] c);
        logic [4:0] sum;
        sum = 5'(card_value(a)) + 5'(card_value(b)) + 5'(card_value(c));
        if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[CARD_W-1:0];
    endfunction

endpackage

// File: rtl/card_datapath_if.sv
// Bundle between the dealer/round state machine and the card datapath.
// master: drives new_card and load strobes, observes scores and displays.
// slave : the datapath side.
interface card_datapath_if #(
    parameter int unsigned SEG_W = 7
);
    logic [3:0]       new_card;
    logic             load_pcard1;
    logic             load_pcard2;
    logic             load_pcard3;
    logic             load_dcard1;
    logic             load_dcard2;
    logic             load_dcard3;
    logic [3:0]       pcard3;
    logic [3:0]       pscore;
    logic [3:0]       dscore;
    logic [SEG_W-1:0] HEX0;
    logic [SEG_W-1:0] HEX1;
    logic [SEG_W-1:0] HEX2;
    logic [SEG_W-1:0] HEX3;
    logic [SEG_W-1:0] HEX4;
    logic [SEG_W-1:0] HEX5;

    modport master (
        output new_card, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
        input  pcard3, pscore, dscore, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  new_card, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
        output pcard3, pscore, dscore, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/card7seg.sv
// Combinational card-code to active-low seven-segment glyph.
// Ports: i_code (4-bit card code), o_seg (SEG_W glyph, blank for empty codes).
module card7seg
    import baccarat_pkg::*;
#(
    parameter int unsigned SEG_W = 7
) (
    input  logic [3:0]       i_code,
    output logic [SEG_W-1:0] o_seg
);

    logic [GLYPH_W-1:0] w_glyph;

    always_comb begin
        w_glyph = SEG_BLANK;
        case (i_code)
            CARD_ACE:   w_glyph = SEG_A;
            4'd2:       w_glyph = SEG_2;
            4'd3:       w_glyph = SEG_3;
            4'd4:       w_glyph = SEG_4;
            4'd5:       w_glyph = SEG_5;
            4'd6:       w_glyph = SEG_6;
            4'd7:       w_glyph = SEG_7;
            4'd8:       w_glyph = SEG_8;
            4'd9:       w_glyph = SEG_9;
            CARD_TEN:   w_glyph = SEG_0;
            CARD_JACK:  w_glyph = SEG_J;
            CARD_QUEEN: w_glyph = SEG_Q;
            CARD_KING:  w_glyph = SEG_K;
            default:    w_glyph = SEG_BLANK;
        endcase
    end

    assign o_seg = SEG_W'(w_glyph);

endmodule

// File: rtl/card_datapath.sv
// Baccarat round datapath: six card registers loaded from new_card by
// independent strobes, mod-10 hand scores, raw player card 3, six displays.
// Ports: slow_clock, resetb (sync, active-low), bus (card_datapath_if.slave):
//   new_card/load_* in; pcard3, pscore, dscore, HEX0..HEX5 out (combinational).
module card_datapath
    import baccarat_pkg::*;
#(
    parameter int unsigned SEG_W = 7
) (
    input  logic            slow_clock,
    input  logic            resetb,
    card_datapath_if.slave  bus
);

    localparam int unsigned NUM_CARDS = 6;

    logic [CARD_W-1:0] r_pc1, r_pc2, r_pc3;
    logic [CARD_W-1:0] r_dc1, r_dc2, r_dc3;
    logic [CARD_W-1:0] w_cards [NUM_CARDS];
    logic [SEG_W-1:0]  w_hex   [NUM_CARDS];

    // Card registers; reset wins over any strobe in the same cycle
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_pc1 <= CARD_EMPTY;
            r_pc2 <= CARD_EMPTY;
            r_pc3 <= CARD_EMPTY;
            r_dc1 <= CARD_EMPTY;
            r_dc2 <= CARD_EMPTY;
            r_dc3 <= CARD_EMPTY;
        end else begin
            if (bus.load_pcard1) r_pc1 <= bus.new_card;
            if (bus.load_pcard2) r_pc2 <= bus.new_card;
            if (bus.load_pcard3) r_pc3 <= bus.new_card;
            if (bus.load_dcard1) r_dc1 <= bus.new_card;
            if (bus.load_dcard2) r_dc2 <= bus.new_card;
            if (bus.load_dcard3) r_dc3 <= bus.new_card;
        end
    end

    assign w_cards[0] = r_pc1;
    assign w_cards[1] = r_pc2;
    assign w_cards[2] = r_pc3;
    assign w_cards[3] = r_dc1;
    assign w_cards[4] = r_dc2;
    assign w_cards[5] = r_dc3;

    // One display decoder per card register, HEX index follows card order
    for (genvar g = 0; g < NUM_CARDS; g++) begin : g_disp
        card7seg #(.SEG_W(SEG_W)) u_seg (
            .i_code (w_cards[g]),
            .o_seg  (w_hex[g])
        );
    end

    assign bus.HEX0   = w_hex[0];
    assign bus.HEX1   = w_hex[1];
    assign bus.HEX2   = w_hex[2];
    assign bus.HEX3   = w_hex[3];
    assign bus.HEX4   = w_hex[4];
    assign bus.HEX5   = w_hex[5];

    assign bus.pscore = mod10_sum3(r_pc1, r_pc2, r_pc3);
    assign bus.dscore = mod10_sum3(r_dc1, r_dc2, r_dc3);
    assign bus.pcard3 = r_pc3;

endmodule

// File: tb/tb_card_datapath.sv
module tb_card_datapath;

    logic slow_clock;
    logic resetb;
    int   checks;
    int   failures;

    // Reference state: raw codes of pc1,pc2,pc3,dc1,dc2,dc3
    logic [3:0] m_card [6];

    card_datapath_if #(.SEG_W(7)) bus ();

    card_datapath #(.SEG_W(7)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    function automatic int ref_val(input logic [3:0] code);
        return (code >= 4'd1 && code <= 4'd9) ? int'(code) : 0;
    endfunction

    // Expected display per card code, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] ref_glyph(input logic [3:0] code);
        case (code)
            4'd1:    return 7'b0001000;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'd10:   return 7'b1000000;
            4'd11:   return 7'b1100001;
            4'd12:   return 7'b0011000;
            4'd13:   return 7'b0001010;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] dut_hex(input int idx);
        case (idx)
            0:       return bus.HEX0;
            1:       return bus.HEX1;
            2:       return bus.HEX2;
            3:       return bus.HEX3;
            4:       return bus.HEX4;
            default: return bus.HEX5;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ps;
        int ds;
        ps = (ref_val(m_card[0]) + ref_val(m_card[1]) + ref_val(m_card[2])) % 10;
        ds = (ref_val(m_card[3]) + ref_val(m_card[4]) + ref_val(m_card[5])) % 10;
        chk({tag, "_pscore"}, 8'(bus.pscore), 8'(ps));
        chk({tag, "_dscore"}, 8'(bus.dscore), 8'(ds));
        chk({tag, "_pcard3"}, 8'(bus.pcard3), 8'(m_card[2]));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_hex%0d", tag, i), 8'(dut_hex(i)), 8'(ref_glyph(m_card[i])));
        end
    endtask

    // One clock edge with the given code/strobe mask/reset; strobe bit i selects card i
    task automatic step(input logic [3:0] code, input logic [5:0] mask, input logic rst_n_v);
        @(negedge slow_clock);
        bus.new_card    = code;
        bus.load_pcard1 = mask[0];
        bus.load_pcard2 = mask[1];
        bus.load_pcard3 = mask[2];
        bus.load_dcard1 = mask[3];
        bus.load_dcard2 = mask[4];
        bus.load_dcard3 = mask[5];
        resetb          = rst_n_v;
        @(posedge slow_clock);
        for (int i = 0; i < 6; i++) begin
            if (!rst_n_v)     m_card[i] = 4'd0;
            else if (mask[i]) m_card[i] = code;
        end
        #1;
        bus.load_pcard1 = 1'b0;
        bus.load_pcard2 = 1'b0;
        bus.load_pcard3 = 1'b0;
        bus.load_dcard1 = 1'b0;
        bus.load_dcard2 = 1'b0;
        bus.load_dcard3 = 1'b0;
        resetb          = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        foreach (m_card[i]) m_card[i] = 4'd0;
        resetb          = 1'b0;
        bus.new_card    = 4'd0;
        bus.load_pcard1 = 1'b0;
        bus.load_pcard2 = 1'b0;
        bus.load_pcard3 = 1'b0;
        bus.load_dcard1 = 1'b0;
        bus.load_dcard2 = 1'b0;
        bus.load_dcard3 = 1'b0;
        repeat (2) @(posedge slow_clock);
        #1;
        resetb = 1'b1;
        check_all("reset");
        chk("reset_hex0_blank", 8'(bus.HEX0), 8'h7f);

        // Reset beats a simultaneous strobe
        step(4'd5, 6'b000001, 1'b0);
        check_all("rst_with_load");

        // Player deal 7 then 9
        step(4'd7, 6'b000001, 1'b1);
        check_all("p1_7");
        step(4'd9, 6'b000010, 1'b1);
        check_all("p2_9");
        chk("plan_pscore_7_9", 8'(bus.pscore), 8'd6);

        // Dealer ten and faces
        step(4'd10, 6'b001000, 1'b1);
        step(4'd13, 6'b010000, 1'b1);
        step(4'd12, 6'b100000, 1'b1);
        check_all("dealer_faces");
        chk("plan_dscore_faces", 8'(bus.dscore), 8'd0);

        // Maximum sum wraps, then a face card on player card 3
        step(4'd9, 6'b000001, 1'b1);
        step(4'd9, 6'b000100, 1'b1);
        check_all("p_999");
        chk("plan_pscore_999", 8'(bus.pscore), 8'd7);
        step(4'd11, 6'b000100, 1'b1);
        check_all("p3_jack");
        chk("plan_pcard3_jack", 8'(bus.pcard3), 8'd11);
        chk("plan_pscore_99j", 8'(bus.pscore), 8'd8);

        // Simultaneous strobes from a fresh round
        step(4'd0, 6'b000000, 1'b0);
        step(4'd3, 6'b000010, 1'b1);
        step(4'd5, 6'b010000, 1'b1);
        step(4'd4, 6'b001001, 1'b1);
        check_all("simul");
        chk("plan_simul_pscore", 8'(bus.pscore), 8'd7);
        chk("plan_simul_dscore", 8'(bus.dscore), 8'd9);

        // Invalid code overwrites a card as empty, then mid-round reset
        step(4'd14, 6'b000010, 1'b1);
        check_all("invalid14");
        chk("plan_hex1_blank", 8'(bus.HEX1), 8'h7f);
        step(4'd15, 6'b000000, 1'b0);
        check_all("midround_rst");

        // Randomized rounds with occasional resets
        for (int n = 0; n < 80; n++) begin
            logic [3:0] code;
            logic [5:0] mask;
            logic       rn;
            code = 4'($urandom_range(0, 15));
            mask = 6'($urandom);
            rn   = ($urandom_range(0, 15) != 0);
            step(code, mask, rn);
            check_all($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
